axis_dac_arbiter: RTL and testbench

//  Shares the two-channel DAC sample stream between two AXI-Stream sources (e.g. main waveform, calibration tone).

---
 rtl/axis_dac_arbiter_pkg.sv | 19 +
 rtl/dac_rr_picker.sv | 42 ++++
 rtl/axis_dac_arbiter.sv | 141 ++++++++++++++
 tb/tb_axis_dac_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dac_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_dac_arbiter_pkg
//   Shared definitions for the DAC stream arbiter: FSM state encoding and the
//   zero sample word emitted whenever no source data is forwarded.
// -----------------------------------------------------------------------------
package axis_dac_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2,
        StGuard  = 2'd3
    } arb_state_e;

    // Wide enough for any sample width; users slice the low bits they need.
    localparam int unsigned MaxWordWidth = 1024;
    localparam logic [MaxWordWidth-1:0] ZeroWord = '0;

endpackage

// File: rtl/dac_rr_picker.sv
// -----------------------------------------------------------------------------
// dac_rr_picker
//   Combinational source pick for the DAC arbiter plus the round-robin pointer.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     valid_i[1:0]  : tvalid of source 1 / source 0
//     prio_i        : 1 = fixed priority (source 0 wins a tie)
//     commit_i      : a grant decision is taken this cycle; update the pointer
//     pick_o[1:0]   : one-hot chosen source, 00 when nothing requests
// -----------------------------------------------------------------------------
module dac_rr_picker (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    input  logic       commit_i,
    output logic [1:0] pick_o
);

    // Set when source 1 was served last, so source 0 wins the next tie.
    // Resets set so that source 0 is served first.
    logic last_s1_q;

    always_comb begin
        pick_o = 2'b00;
        case (valid_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = (prio_i || last_s1_q) ? 2'b01 : 2'b10;
            default: pick_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_s1_q <= 1'b1;
        end else if (commit_i && (pick_o != 2'b00)) begin
            last_s1_q <= pick_o[1];
        end
    end

endmodule

// File: rtl/axis_dac_arbiter.sv
// -----------------------------------------------------------------------------
// axis_dac_arbiter
//   Shares the DAC sample stream between two AXI-Stream sources, one whole
//   (tlast-delimited) frame at a time, with cfg_guard zero words between
//   frames. m_axis_tvalid stays high from the first clock after reset so the
//   DAC core never drops back to its idle path; zero words fill every gap.
//   Ports:
//     aclk, aresetn        : clock, asynchronous active-low reset
//     cfg_prio             : 0 = round-robin, 1 = fixed priority (s0 wins)
//     cfg_guard            : zero words inserted after each frame
//     s0_axis_*, s1_axis_* : source streams (tdata/tvalid/tlast in, tready out)
//     m_axis_*             : registered stream towards the DAC core
//     sts_grant            : one-hot current owner, 00 = none
//     sts_underrun         : saturating count of fill words inserted mid-frame
// -----------------------------------------------------------------------------
module axis_dac_arbiter
    import axis_dac_arbiter_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned GUARD_WIDTH      = 8,
    parameter int unsigned UNDERRUN_WIDTH   = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_prio,
    input  logic [GUARD_WIDTH-1:0]      cfg_guard,
    input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                        s0_axis_tvalid,
    input  logic                        s0_axis_tlast,
    output logic                        s0_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                        s1_axis_tvalid,
    input  logic                        s1_axis_tlast,
    output logic                        s1_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [1:0]                  sts_grant,
    output logic [UNDERRUN_WIDTH-1:0]   sts_underrun
);

    localparam logic [AXIS_TDATA_WIDTH-1:0] Zero        = ZeroWord[AXIS_TDATA_WIDTH-1:0];
    localparam logic [GUARD_WIDTH-1:0]      GuardOne    = 1;
    localparam logic [UNDERRUN_WIDTH-1:0]   UnderrunOne = 1;

    arb_state_e                  state_q;
    logic                        tvalid_q;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic [1:0]                  grant_q;
    logic [GUARD_WIDTH-1:0]      guard_q;
    logic [UNDERRUN_WIDTH-1:0]   underrun_q;

    logic                        adv;
    logic [1:0]                  pick;
    logic                        src_valid;
    logic                        src_last;
    logic [AXIS_TDATA_WIDTH-1:0] src_data;

    // Everything, including the FSM, only moves when the DAC core takes a word.
    assign adv = m_axis_tready;

    dac_rr_picker u_picker (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .valid_i  ({s1_axis_tvalid, s0_axis_tvalid}),
        .prio_i   (cfg_prio),
        .commit_i (adv && (state_q == StIdle)),
        .pick_o   (pick)
    );

    // Stream of the granted source (only meaningful in the grant states).
    always_comb begin
        src_valid = s0_axis_tvalid;
        src_last  = s0_axis_tlast;
        src_data  = s0_axis_tdata;
        if (state_q == StGrant1) begin
            src_valid = s1_axis_tvalid;
            src_last  = s1_axis_tlast;
            src_data  = s1_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            tvalid_q   <= 1'b0;
            tdata_q    <= Zero;
            grant_q    <= 2'b00;
            guard_q    <= '0;
            underrun_q <= '0;
        end else begin
            tvalid_q <= 1'b1;
            if (adv) begin
                unique case (state_q)
                    StIdle: begin
                        tdata_q <= Zero;
                        if (pick == 2'b01) begin
                            state_q <= StGrant0;
                            grant_q <= 2'b01;
                        end else if (pick == 2'b10) begin
                            state_q <= StGrant1;
                            grant_q <= 2'b10;
                        end
                    end
                    StGrant0, StGrant1: begin
                        if (src_valid) begin
                            tdata_q <= src_data;
                            if (src_last) begin
                                guard_q <= cfg_guard;
                                grant_q <= 2'b00;
                                state_q <= (cfg_guard != '0) ? StGuard : StIdle;
                            end
                        end else begin
                            // Source starved mid-frame: fill with zero, keep the grant.
                            tdata_q <= Zero;
                            if (underrun_q != '1) begin
                                underrun_q <= underrun_q + UnderrunOne;
                            end
                        end
                    end
                    StGuard: begin
                        tdata_q <= Zero;
                        guard_q <= guard_q - GuardOne;
                        if (guard_q == GuardOne) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign s0_axis_tready = adv && (state_q == StGrant0);
    assign s1_axis_tready = adv && (state_q == StGrant1);
    assign m_axis_tdata   = tdata_q;
    assign m_axis_tvalid  = tvalid_q;
    assign sts_grant      = grant_q;
    assign sts_underrun   = underrun_q;

endmodule

// File: tb/tb_axis_dac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_dac_arbiter
//   Directed bench for axis_dac_arbiter. Inputs change and outputs are checked
//   on the falling clock edge; the DUT acts on the rising edge. The underrun
//   counter is built 3 bits wide so saturation is reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_axis_dac_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_prio;
    logic [7:0]  cfg_guard;
    logic [31:0] s0_axis_tdata;
    logic        s0_axis_tvalid;
    logic        s0_axis_tlast;
    logic        s0_axis_tready;
    logic [31:0] s1_axis_tdata;
    logic        s1_axis_tvalid;
    logic        s1_axis_tlast;
    logic        s1_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [1:0]  sts_grant;
    logic [2:0]  sts_underrun;

    int checks = 0;
    int passed = 0;

    // Source model state for the streaming test.
    int         b0, b1;
    logic       acc0, acc1;
    logic [1:0] prev_grant;
    logic [1:0] g_seq[$];
    int         n_s0, n_s1;

    always #5 aclk = ~aclk;

    axis_dac_arbiter #(
        .AXIS_TDATA_WIDTH (32),
        .GUARD_WIDTH      (8),
        .UNDERRUN_WIDTH   (3)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_prio       (cfg_prio),
        .cfg_guard      (cfg_guard),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .sts_grant      (sts_grant),
        .sts_underrun   (sts_underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge aclk);
    endtask

    task automatic clear_inputs();
        s0_axis_tdata  = '0;
        s0_axis_tvalid = 1'b0;
        s0_axis_tlast  = 1'b0;
        s1_axis_tdata  = '0;
        s1_axis_tvalid = 1'b0;
        s1_axis_tlast  = 1'b0;
        m_axis_tready  = 1'b1;
    endtask

    // Short asynchronous reset pulse between edges; ends one clock after release.
    task automatic pulse_reset();
        #1 aresetn = 1'b0;
        clear_inputs();
        #2 aresetn = 1'b1;
        cyc();
    endtask

    // Both sources stream back-to-back 2-beat frames; log each new grant.
    task automatic run_sources(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (acc0) b0 = (b0 + 1) % 2;
            if (acc1) b1 = (b1 + 1) % 2;
            s0_axis_tvalid = 1'b1;
            s0_axis_tlast  = (b0 == 1);
            s0_axis_tdata  = 32'hA000_0000 | 32'(b0);
            s1_axis_tvalid = 1'b1;
            s1_axis_tlast  = (b1 == 1);
            s1_axis_tdata  = 32'hB000_0000 | 32'(b1);
            acc0 = s0_axis_tready && s0_axis_tvalid;
            acc1 = s1_axis_tready && s1_axis_tvalid;
            if ((sts_grant != 2'b00) && (prev_grant == 2'b00)) g_seq.push_back(sts_grant);
            prev_grant = sts_grant;
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- 1: reset and release with no sources ----
        aresetn   = 1'b0;
        cfg_prio  = 1'b0;
        cfg_guard = 8'd3;
        clear_inputs();
        repeat (2) cyc();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_grant", sts_grant, 0);
        #1 aresetn = 1'b1;
        cyc();
        chk("rel_tvalid", m_axis_tvalid, 1);
        chk("rel_tdata", m_axis_tdata, 0);
        chk("rel_grant", sts_grant, 0);
        chk("rel_s0_tready", s0_axis_tready, 0);
        chk("rel_s1_tready", s1_axis_tready, 0);
        chk("rel_underrun", sts_underrun, 0);

        // ---- 2: 4-beat s0 frame, guard 3 ----
        s0_axis_tvalid = 1'b1;
        s0_axis_tdata  = 32'h0001_0001;
        cyc();
        chk("t2_grant", sts_grant, 2'b01);
        chk("t2_s0_tready", s0_axis_tready, 1);
        chk("t2_idle_zero", m_axis_tdata, 0);
        for (int k = 1; k <= 4; k++) begin
            s0_axis_tdata = {16'(k), 16'(k)};
            s0_axis_tlast = (k == 4);
            cyc();
            chk("t2_beat", m_axis_tdata, {16'(k), 16'(k)});
        end
        chk("t2_grant_end", sts_grant, 0);
        // Next frame is already requesting; it must wait out the guard.
        s0_axis_tdata = 32'h0005_0005;
        s0_axis_tlast = 1'b1;
        for (int g = 0; g < 3; g++) begin
            cyc();
            chk("t2_guard_zero", m_axis_tdata, 0);
            chk("t2_guard_grant", sts_grant, 0);
            chk("t2_guard_tready", s0_axis_tready, 0);
        end
        cyc();
        chk("t2_regrant", sts_grant, 2'b01);
        cfg_guard = 8'd0;
        cyc();
        chk("t2_single_beat", m_axis_tdata, 32'h0005_0005);
        chk("t2_single_grant", sts_grant, 0);
        s0_axis_tvalid = 1'b0;
        s0_axis_tlast  = 1'b0;
        cyc();
        chk("t2_noguard_zero", m_axis_tdata, 0);
        chk("t2_noguard_idle", s0_axis_tready, 0);

        // ---- 3: round-robin, then fixed priority ----
        pulse_reset();
        cfg_guard  = 8'd1;
        cfg_prio   = 1'b0;
        b0 = 0; b1 = 0; acc0 = 1'b0; acc1 = 1'b0; prev_grant = 2'b00;
        run_sources(24);
        chk("t3_rr_count_ge4", 32'(g_seq.size() >= 4), 1);
        if (g_seq.size() >= 4) begin
            chk("t3_rr_g0", g_seq[0], 2'b01);
            chk("t3_rr_g1", g_seq[1], 2'b10);
            chk("t3_rr_g2", g_seq[2], 2'b01);
            chk("t3_rr_g3", g_seq[3], 2'b10);
        end
        cfg_prio = 1'b1;
        g_seq.delete();
        run_sources(30);
        n_s0 = 0;
        n_s1 = 0;
        foreach (g_seq[i]) begin
            if (g_seq[i] == 2'b01) n_s0++;
            if (g_seq[i] == 2'b10) n_s1++;
        end
        chk("t3_prio_s1_grants", n_s1, 0);
        chk("t3_prio_s0_ge4", 32'(n_s0 >= 4), 1);

        // ---- 4: underrun on s1, saturation of a 3-bit counter ----
        pulse_reset();
        cfg_prio       = 1'b0;
        cfg_guard      = 8'd2;
        s1_axis_tvalid = 1'b1;
        s1_axis_tdata  = 32'h1111_2222;
        cyc();
        chk("t4_grant", sts_grant, 2'b10);
        chk("t4_s1_tready", s1_axis_tready, 1);
        chk("t4_s0_tready", s0_axis_tready, 0);
        cyc();
        chk("t4_d1", m_axis_tdata, 32'h1111_2222);
        s1_axis_tvalid = 1'b0;
        for (int u = 0; u < 5; u++) begin
            cyc();
            chk("t4_fill_zero", m_axis_tdata, 0);
            chk("t4_fill_grant", sts_grant, 2'b10);
        end
        chk("t4_underrun5", sts_underrun, 5);
        s1_axis_tvalid = 1'b1;
        s1_axis_tdata  = 32'h3333_4444;
        cyc();
        chk("t4_d2", m_axis_tdata, 32'h3333_4444);
        chk("t4_underrun_hold", sts_underrun, 5);
        s1_axis_tvalid = 1'b0;
        repeat (3) cyc();
        chk("t4_underrun_sat", sts_underrun, 7);
        chk("t4_sat_grant", sts_grant, 2'b10);
        s1_axis_tvalid = 1'b1;
        s1_axis_tdata  = 32'h5555_6666;
        s1_axis_tlast  = 1'b1;
        cyc();
        chk("t4_d3", m_axis_tdata, 32'h5555_6666);
        chk("t4_end_grant", sts_grant, 0);
        s1_axis_tvalid = 1'b0;
        s1_axis_tlast  = 1'b0;
        cyc();
        chk("t4_guard_no_underrun", sts_underrun, 7);

        // ---- 5: output stall mid-frame and during guard ----
        pulse_reset();
        chk("t5_underrun_cleared", sts_underrun, 0);
        cfg_guard      = 8'd2;
        s0_axis_tvalid = 1'b1;
        s0_axis_tdata  = 32'hE000_0001;
        cyc();
        chk("t5_grant", sts_grant, 2'b01);
        cyc();
        chk("t5_e1", m_axis_tdata, 32'hE000_0001);
        s0_axis_tdata = 32'hE000_0002;
        m_axis_tready = 1'b0;
        #1;
        chk("t5_stall_s0_tready", s0_axis_tready, 0);
        chk("t5_stall_s1_tready", s1_axis_tready, 0);
        for (int s = 0; s < 3; s++) begin
            cyc();
            chk("t5_stall_hold", m_axis_tdata, 32'hE000_0001);
            chk("t5_stall_tvalid", m_axis_tvalid, 1);
        end
        m_axis_tready = 1'b1;
        cyc();
        chk("t5_e2", m_axis_tdata, 32'hE000_0002);
        s0_axis_tdata = 32'hE000_0003;
        s0_axis_tlast = 1'b1;
        cyc();
        chk("t5_e3", m_axis_tdata, 32'hE000_0003);
        chk("t5_end_grant", sts_grant, 0);
        s0_axis_tdata = 32'hF000_0001;
        s0_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc();
            chk("t5_guard_stall_hold", m_axis_tdata, 32'hE000_0003);
        end
        m_axis_tready = 1'b1;
        cyc();
        chk("t5_guard1_zero", m_axis_tdata, 0);
        chk("t5_guard1_grant", sts_grant, 0);
        cyc();
        chk("t5_guard2_zero", m_axis_tdata, 0);
        chk("t5_guard2_grant", sts_grant, 0);
        cyc();
        chk("t5_regrant", sts_grant, 2'b01);

        // ---- 6: asynchronous reset mid-frame ----
        cyc();
        chk("t6_f1", m_axis_tdata, 32'hF000_0001);
        s0_axis_tdata = 32'hF000_0002;
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_tdata", m_axis_tdata, 0);
        chk("t6_rst_grant", sts_grant, 0);
        chk("t6_rst_tready", s0_axis_tready, 0);
        s0_axis_tvalid = 1'b1;
        s0_axis_tdata  = 32'h6060_0000;
        s0_axis_tlast  = 1'b1;
        s1_axis_tvalid = 1'b1;
        s1_axis_tdata  = 32'h7070_0000;
        s1_axis_tlast  = 1'b1;
        cyc();
        #2 aresetn = 1'b1;
        cyc();
        chk("t6_tie_s0", sts_grant, 2'b01);
        chk("t6_tvalid", m_axis_tvalid, 1);
        chk("t6_fresh_zero", m_axis_tdata, 0);
        cyc();
        chk("t6_g0", m_axis_tdata, 32'h6060_0000);
        chk("t6_end_grant", sts_grant, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
